instruction_register: RTL and testbench

Multicycle-datapath instruction register. Captures the 32-bit instruction word from memory when the control unit asserts the write enable. It then holds that word stable and exposes its MIPS field decodings to the control unit, register file, sign-extender and jump-address logic for the rest of the instruction's execution.

---
 rtl/instruction_register_if.sv | 30 +++
 rtl/instruction_register.sv | 35 +++
 tb/tb_instruction_register.sv | 112 +++++++++++
 3 files changed

// File: rtl/instruction_register_if.sv
//------------------------------------------------------------------------------
// instruction_register_if : load port and decoded-field bus of the IR
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instruction_register_if;
  logic        IRWrite;
  logic [31:0] instr_in;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] jta;

  modport master (
    output IRWrite, instr_in,
    input  op, rs, rt, rd, shamt, funct, imm, jta
  );

  modport slave (
    input  IRWrite, instr_in,
    output op, rs, rt, rd, shamt, funct, imm, jta
  );
endinterface

`default_nettype wire

// File: rtl/instruction_register.sv
//------------------------------------------------------------------------------
// instruction_register : holds the fetched MIPS word and exposes its fields
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instruction_register (
  input  wire                          clk,
  input  wire                          reset,
  instruction_register_if.slave        bus
);

  logic [31:0] r_held;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_held <= 32'h0000_0000;
    end else if (bus.IRWrite) begin
      r_held <= bus.instr_in;
    end
  end

  // Overlapping slices: imm = {rd,shamt,funct}, jta = {rs,rt,imm}
  assign bus.op    = r_held[31:26];
  assign bus.rs    = r_held[25:21];
  assign bus.rt    = r_held[20:16];
  assign bus.rd    = r_held[15:11];
  assign bus.shamt = r_held[10:6];
  assign bus.funct = r_held[5:0];
  assign bus.imm   = r_held[15:0];
  assign bus.jta   = r_held[25:0];

endmodule

`default_nettype wire

// File: tb/tb_instruction_register.sv
//------------------------------------------------------------------------------
// tb_instruction_register : directed plus randomized check against a word model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_register;

  logic        clk = 1'b0;
  logic        reset;
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model;

  instruction_register_if bus ();

  instruction_register dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected fields derived from the word by integer division and modulo
  task automatic check_all(input string tag);
    cmp({tag, ".op"},    32'(bus.op),    model / 32'd67108864);
    cmp({tag, ".rs"},    32'(bus.rs),    (model / 32'd2097152) % 32'd32);
    cmp({tag, ".rt"},    32'(bus.rt),    (model / 32'd65536) % 32'd32);
    cmp({tag, ".rd"},    32'(bus.rd),    (model / 32'd2048) % 32'd32);
    cmp({tag, ".shamt"}, 32'(bus.shamt), (model / 32'd64) % 32'd32);
    cmp({tag, ".funct"}, 32'(bus.funct), model % 32'd64);
    cmp({tag, ".imm"},   32'(bus.imm),   model % 32'd65536);
    cmp({tag, ".jta"},   32'(bus.jta),   model % 32'd67108864);
  endtask

  // Apply one edge; the model follows the reset > load > hold rule
  task automatic step(input logic r, input logic w, input logic [31:0] d);
    reset        = r;
    bus.IRWrite  = w;
    bus.instr_in = d;
    @(posedge clk);
    if (r)      model = 32'h0;
    else if (w) model = d;
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.instr_in = 32'h0;
    @(negedge clk);

    step(1'b1, 1'b0, 32'h0000_0000);
    check_all("reset");

    step(1'b0, 1'b0, 32'h212A_000A);
    check_all("gated");

    step(1'b0, 1'b1, 32'h212A_000A);
    check_all("itype");
    cmp("itype.op_const",  32'(bus.op),  32'h08);
    cmp("itype.rs_const",  32'(bus.rs),  32'd9);
    cmp("itype.rt_const",  32'(bus.rt),  32'd10);
    cmp("itype.imm_const", 32'(bus.imm), 32'h000A);
    cmp("itype.jta_const", 32'(bus.jta), 32'h012A_000A);

    step(1'b0, 1'b1, 32'h012A_4020);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'hFFFF_FFFF);
      check_all("rtype_hold");
    end
    cmp("rtype.rd_const",    32'(bus.rd),    32'd8);
    cmp("rtype.funct_const", 32'(bus.funct), 32'h20);
    cmp("rtype.jta_const",   32'(bus.jta),   32'h012A_4020);

    step(1'b1, 1'b1, 32'h0800_0010);
    check_all("reset_prio");
    cmp("reset_prio.jta_const", 32'(bus.jta), 32'h0);

    step(1'b0, 1'b1, 32'h0800_0010);
    check_all("jtype");
    cmp("jtype.op_const",  32'(bus.op),  32'h02);
    cmp("jtype.jta_const", 32'(bus.jta), 32'h10);

    step(1'b0, 1'b1, 32'hAC85_0004);
    cmp("b2b1.op_const", 32'(bus.op), 32'h2B);
    check_all("b2b1");
    step(1'b0, 1'b1, 32'h8C85_0004);
    cmp("b2b2.op_const", 32'(bus.op), 32'h23);
    check_all("b2b2");

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, $urandom);
      check_all("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
